exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset (sampled on rising edge of clk).
REQ-003 instruction  in  32  current RV64 instruction; opcode [6:0], funct3 [14:12], funct7 [31:25].
REQ-004 rs1_data  in  64  ALU operand x.
REQ-005 rs2_data  in  64  register operand for ALU y.
REQ-006 imm  in  64  sign-extended immediate for ALU y.
REQ-007 ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  main-control signals.
REQ-008 ALUOp  out  2  main-control to ALU-control class code.
REQ-009 ALUIn  out  4  ALU operation select.
REQ-010 out  out  64  combinational ALU result.
REQ-011 zr  out  1  combinational zero flag, 1 when out == 0.
REQ-012 out_q  out  64  registered ALU result.
REQ-013 zr_q  out  1  registered zero flag.

Function
REQ-014 Main decode on opcode, purely combinational; listed as ALUsrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp.
REQ-015 0110011 (R-type): 0,0,1,0,0,0,10.
REQ-016 0010011 (I-arith): 1,0,1,0,0,0,11.
REQ-017 0000011 (load): 1,1,1,1,0,0,00.
REQ-018 0100011 (store): 1,0,0,0,1,0,00.
REQ-019 1100011 (beq): 0,0,0,0,0,1,01.
REQ-020 Any other opcode: all control outputs 0, ALUOp 00.
REQ-021 ALU control: ALUOp 00 -> ADD 0010; 01 -> SUB 0110.
REQ-022 ALUOp 10, by funct3: 000 -> ADD 0010, or SUB 0110 when funct7 = 0100000; 111 -> AND 0000; 110 -> OR 0001; 100 -> XOR 0011; 001 -> SLL 0100; 101 -> SRL 0101, or SRA 1000 when funct7 = 0100000; 010 -> SLT 0111; 011 -> SLTU 1001.
REQ-023 ALUOp 11: same funct3 map as REQ-022, except 000 is always ADD; 101 uses funct7[31:26] = 010000 for SRA.
REQ-024 Any unlisted combination -> ALUIn 0010 (ADD).
REQ-025 y operand = imm when ALUsrc = 1, else rs2_data.
REQ-026 ALU, 64-bit, combinational: AND, OR, XOR bitwise; ADD/SUB modulo 2^64, no carry/overflow output; SLL/SRL/SRA shift by y[5:0]; SLT signed compare; SLTU unsigned compare; both give 64'd1 or 64'd0.
REQ-027 Undefined ALUIn codes produce out = 0.
REQ-028 zr = (out == 64'd0) in every mode, including SUB used for beq.
REQ-029 Each rising clk with reset = 0: out_q <= out, zr_q <= zr; no enable, no stall.
REQ-030 Combinational outputs are independent of reset and clk; out and zr are valid in the same cycle (zero latency); out_q and zr_q have one-cycle latency.

Reset
REQ-031 reset = 1 at a rising edge: out_q <= 0, zr_q <= 0; this overrides the update in REQ-029.
REQ-032 Reset asserted mid-stream clears only the registers; decode and ALU outputs keep tracking their inputs.

Structure
REQ-033 Shared package holds the opcode constants, the ALUOp encodings (00/01/10/11) and the 4-bit ALUIn operation constants.
REQ-034 Sub-modules: main decoder exec_decode, ALU-control and ALU as separate combinational blocks inside exec_unit; the output register lives in the top.

Verification
REQ-035 add x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7 -> RegWrite = 1, ALUOp = 10, ALUIn = 0010, out = 12, zr = 0; out_q = 12 after next edge.
REQ-036 sub (funct7 0100000), rs1 = rs2 = 9 -> ALUIn = 0110, out = 0, zr = 1.
REQ-037 ld (opcode 0000011), rs1 = 0x100, imm = 8 -> ALUsrc = MemRead = MemtoReg = RegWrite = 1, out = 0x108.
REQ-038 beq, rs1 = 4, rs2 = 4 -> Branch = 1, ALUOp = 01, zr = 1; with rs2 = 5 -> zr = 0.
REQ-039 sra, rs1 = 0x8000000000000000, rs2 = 4 -> out = 0xF800000000000000; slt with rs1 = -1, rs2 = 1 -> out = 1; sltu with the same operands -> out = 0.
REQ-040 Load out_q with nonzero data, then assert reset for one edge -> out_q = 0, zr_q = 0; after release, out_q follows out on the next edge.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared constants for the exec_unit slice: opcodes, ALUOp classes, ALU operation codes,
// the main-control bundle and the funct3-to-operation mapping shared by R- and I-type.
package exec_unit_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_MEM};

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b001:  op = ALU_SLL;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Operand/instruction bus into exec_unit and the control/result signals it produces.
interface exec_unit_if;
    logic [31:0] instruction;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic        ALUsrc;
    logic        MemtoReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic [1:0]  ALUOp;
    logic [3:0]  ALUIn;
    logic [63:0] out;
    logic        zr;
    logic [63:0] out_q;
    logic        zr_q;

    modport master (
        output instruction, rs1_data, rs2_data, imm,
        input  ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
        input  ALUOp, ALUIn, out, zr, out_q, zr_q
    );

    modport slave (
        input  instruction, rs1_data, rs2_data, imm,
        output ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
        output ALUOp, ALUIn, out, zr, out_q, zr_q
    );
endinterface

// File: rtl/exec_unit_decode.sv
// Main control decoder: maps the 7-bit opcode onto the main-control bundle.
module exec_decode
    import exec_unit_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    // Opcode to control-signal table; unknown opcodes leave everything inactive
    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            OP_RTYPE:  ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_R};
            OP_IARITH: ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_I};
            OP_LOAD:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_MEM};
            OP_STORE:  ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_MEM};
            OP_BRANCH: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_BR};
            default:   ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Single-cycle RV64 execute slice: main decode, ALU control, 64-bit ALU and a
// registered copy of the result and zero flag.
module exec_unit
    import exec_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    exec_unit_if.slave  bus
);

    ctrl_t       ctrl_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [3:0]  alu_in_s;
    logic [63:0] x_s;
    logic [63:0] y_s;
    logic [63:0] alu_out_s;
    logic        zr_s;
    logic [63:0] out_q_r;
    logic        zr_q_r;

    exec_decode u_decode (
        .opcode (bus.instruction[6:0]),
        .ctrl   (ctrl_s)
    );

    assign funct3_s = bus.instruction[14:12];
    assign funct7_s = bus.instruction[31:25];

    // ALU control; I-type shifts only look at funct7[6:1] since bit 25 belongs to shamt
    always_comb begin
        alu_in_s = ALU_ADD;
        case (ctrl_s.alu_op)
            ALUOP_MEM: alu_in_s = ALU_ADD;
            ALUOP_BR:  alu_in_s = ALU_SUB;
            ALUOP_R:   alu_in_s = alu_from_funct3(funct3_s, funct7_s == 7'b0100000);
            ALUOP_I: begin
                if (funct3_s == 3'b000) begin
                    alu_in_s = ALU_ADD;
                end else begin
                    alu_in_s = alu_from_funct3(funct3_s, funct7_s[6:1] == 6'b010000);
                end
            end
            default:   alu_in_s = ALU_ADD;
        endcase
    end

    assign x_s = bus.rs1_data;
    assign y_s = ctrl_s.alu_src ? bus.imm : bus.rs2_data;

    // 64-bit ALU datapath
    always_comb begin
        alu_out_s = 64'd0;
        case (alu_in_s)
            ALU_AND:  alu_out_s = x_s & y_s;
            ALU_OR:   alu_out_s = x_s | y_s;
            ALU_ADD:  alu_out_s = x_s + y_s;
            ALU_XOR:  alu_out_s = x_s ^ y_s;
            ALU_SLL:  alu_out_s = x_s << y_s[5:0];
            ALU_SRL:  alu_out_s = x_s >> y_s[5:0];
            ALU_SUB:  alu_out_s = x_s - y_s;
            ALU_SLT:  alu_out_s = {63'd0, $signed(x_s) < $signed(y_s)};
            ALU_SRA:  alu_out_s = $signed(x_s) >>> y_s[5:0];
            ALU_SLTU: alu_out_s = {63'd0, x_s < y_s};
            default:  alu_out_s = 64'd0;
        endcase
    end

    assign zr_s = (alu_out_s == 64'd0);

    // Result register; reset wins over the per-cycle capture
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q_r <= 64'd0;
            zr_q_r  <= 1'b0;
        end else begin
            out_q_r <= alu_out_s;
            zr_q_r  <= zr_s;
        end
    end

    assign bus.ALUsrc   = ctrl_s.alu_src;
    assign bus.MemtoReg = ctrl_s.mem_to_reg;
    assign bus.RegWrite = ctrl_s.reg_write;
    assign bus.MemRead  = ctrl_s.mem_read;
    assign bus.MemWrite = ctrl_s.mem_write;
    assign bus.Branch   = ctrl_s.branch;
    assign bus.ALUOp    = ctrl_s.alu_op;
    assign bus.ALUIn    = alu_in_s;
    assign bus.out      = alu_out_s;
    assign bus.zr       = zr_s;
    assign bus.out_q    = out_q_r;
    assign bus.zr_q     = zr_q_r;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: instruction-level reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_exec_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic check_en;

    exec_unit_if bus ();

    exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction-level reference: what the instruction means, computed directly
    function automatic void model(input logic [31:0] ins, input logic [63:0] a,
                                  input logic [63:0] r2, input logic [63:0] im,
                                  output logic [7:0] ctl, output logic [3:0] sel,
                                  output logic [63:0] res);
        logic [63:0] b;
        logic [2:0]  f3;
        logic        rt;
        logic        alt;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: ctl = 8'b00100010;
            7'b0010011: ctl = 8'b10100011;
            7'b0000011: ctl = 8'b11110000;
            7'b0100011: ctl = 8'b10001000;
            7'b1100011: ctl = 8'b00000101;
            default:    ctl = 8'b00000000;
        endcase
        b   = ctl[7] ? im : r2;
        rt  = (ins[6:0] == 7'b0110011);
        alt = rt ? (ins[31:25] == 7'b0100000) : (ins[31:26] == 6'b010000);
        if (rt || ins[6:0] == 7'b0010011) begin
            case (f3)
                3'd0: if (rt && alt) begin sel = 4'd6; res = a - b; end
                      else begin sel = 4'd2; res = a + b; end
                3'd7: begin sel = 4'd0; res = a & b; end
                3'd6: begin sel = 4'd1; res = a | b; end
                3'd4: begin sel = 4'd3; res = a ^ b; end
                3'd1: begin sel = 4'd4; res = a << b[5:0]; end
                3'd5: if (alt) begin sel = 4'd8; res = $signed(a) >>> b[5:0]; end
                      else begin sel = 4'd5; res = a >> b[5:0]; end
                3'd2: begin sel = 4'd7; res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; end
                default: begin sel = 4'd9; res = (a < b) ? 64'd1 : 64'd0; end
            endcase
        end else if (ins[6:0] == 7'b1100011) begin
            sel = 4'd6; res = a - b;
        end else begin
            sel = 4'd2; res = a + b;
        end
    endfunction

    logic [63:0] exp_q;
    logic        exp_zq;
    logic [7:0]  pm_ctl;
    logic [3:0]  pm_sel;
    logic [63:0] pm_res;

    // Expected register contents, advanced on every rising edge
    always @(posedge clk) begin
        model(bus.instruction, bus.rs1_data, bus.rs2_data, bus.imm, pm_ctl, pm_sel, pm_res);
        if (reset) begin
            exp_q  <= 64'd0;
            exp_zq <= 1'b0;
        end else begin
            exp_q  <= pm_res;
            exp_zq <= (pm_res == 64'd0);
        end
    end

    logic [7:0]  cm_ctl;
    logic [3:0]  cm_sel;
    logic [63:0] cm_res;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            model(bus.instruction, bus.rs1_data, bus.rs2_data, bus.imm, cm_ctl, cm_sel, cm_res);
            chk("ctrl", {56'd0, bus.ALUsrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
                         bus.MemWrite, bus.Branch, bus.ALUOp}, {56'd0, cm_ctl});
            chk("ALUIn", {60'd0, bus.ALUIn}, {60'd0, cm_sel});
            chk("out", bus.out, cm_res);
            chk("zr", {63'd0, bus.zr}, {63'd0, cm_res == 64'd0});
            chk("out_q", bus.out_q, exp_q);
            chk("zr_q", {63'd0, bus.zr_q}, {63'd0, exp_zq});
        end
    end

    task automatic step(input logic [31:0] ins, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im);
        @(posedge clk);
        #1;
        bus.instruction = ins;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
        bus.imm         = im;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        check_en = 1'b0;
        reset = 1'b1;
        bus.instruction = 32'd0;
        bus.rs1_data = 64'd0;
        bus.rs2_data = 64'd0;
        bus.imm = 64'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_out_q", bus.out_q, 64'd0);
        chk("reset_zr_q", {63'd0, bus.zr_q}, 64'd0);
        reset = 1'b0;

        // add x3,x1,x2
        step(32'h002081B3, 64'd5, 64'd7, 64'd0);
        chk("add_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        chk("add_aluop", {62'd0, bus.ALUOp}, 64'd2);
        chk("add_aluin", {60'd0, bus.ALUIn}, 64'd2);
        chk("add_out", bus.out, 64'd12);
        chk("add_zr", {63'd0, bus.zr}, 64'd0);

        // sub with equal operands
        step(32'h402081B3, 64'd9, 64'd9, 64'd0);
        chk("add_out_q", bus.out_q, 64'd12);
        chk("sub_aluin", {60'd0, bus.ALUIn}, 64'd6);
        chk("sub_out", bus.out, 64'd0);
        chk("sub_zr", {63'd0, bus.zr}, 64'd1);

        // ld x3,8(x1)
        step(32'h0080B183, 64'h100, 64'd77, 64'd8);
        chk("ld_ctrl", {60'd0, bus.ALUsrc, bus.MemRead, bus.MemtoReg, bus.RegWrite}, 64'hF);
        chk("ld_out", bus.out, 64'h108);

        // reset mid-stream with ld still applied
        @(posedge clk);
        #1;
        chk("ld_out_q", bus.out_q, 64'h108);
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_q", bus.out_q, 64'd0);
        chk("midrst_zr_q", {63'd0, bus.zr_q}, 64'd0);
        chk("midrst_out", bus.out, 64'h108);
        @(posedge clk);
        #1;
        chk("postrst_out_q", bus.out_q, 64'h108);

        // beq equal / not equal
        step(32'h00208063, 64'd4, 64'd4, 64'd0);
        chk("beq_branch", {63'd0, bus.Branch}, 64'd1);
        chk("beq_aluop", {62'd0, bus.ALUOp}, 64'd1);
        chk("beq_zr_eq", {63'd0, bus.zr}, 64'd1);
        step(32'h00208063, 64'd4, 64'd5, 64'd0);
        chk("beq_zr_ne", {63'd0, bus.zr}, 64'd0);

        // sra, slt, sltu
        step(32'h4020D1B3, 64'h8000000000000000, 64'd4, 64'd0);
        chk("sra_out", bus.out, 64'hF800000000000000);
        step(32'h0020A1B3, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0);
        chk("slt_out", bus.out, 64'd1);
        step(32'h0020B1B3, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0);
        chk("sltu_out", bus.out, 64'd0);

        // srai with shamt 36 (bit 25 set), addi whose funct7 looks like SUB
        step(32'h4240D193, 64'h8000000000000000, 64'd0, 64'd36);
        chk("srai_aluin", {60'd0, bus.ALUIn}, 64'd8);
        chk("srai_out", bus.out, 64'hFFFFFFFFF8000000);
        step(32'h40008193, 64'd10, 64'd99, 64'd3);
        chk("addi_alt_out", bus.out, 64'd13);

        // store, unknown opcode, and a few logic/shift ops
        step(32'h0020B423, 64'h200, 64'd5, 64'h10);
        chk("sd_memwrite", {63'd0, bus.MemWrite}, 64'd1);
        chk("sd_out", bus.out, 64'h210);
        step(32'h0000007F, 64'd3, 64'd4, 64'd100);
        chk("unk_ctrl", {56'd0, bus.ALUsrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
                         bus.MemWrite, bus.Branch, bus.ALUOp}, 64'd0);
        chk("unk_out", bus.out, 64'd7);
        step(32'h0020F1B3, 64'hF0F0, 64'h0FF0, 64'd0);
        chk("and_out", bus.out, 64'h00F0);
        step(32'h0020E1B3, 64'hF000, 64'h000F, 64'd0);
        chk("or_out", bus.out, 64'hF00F);
        step(32'h0020C1B3, 64'hFF, 64'h0F, 64'd0);
        chk("xor_out", bus.out, 64'hF0);
        step(32'h002091B3, 64'd1, 64'd67, 64'd0);
        chk("sll_out", bus.out, 64'd8);
        step(32'h0020D1B3, 64'h8000000000000000, 64'd63, 64'd0);
        chk("srl_out", bus.out, 64'd1);
        step(32'h0050E193, 64'd0, 64'd0, 64'd0);
        chk("ori_zero_zr", {63'd0, bus.zr}, 64'd1);

        @(posedge clk);
        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
